// File: rtl/fwd_operand_reg.sv
// Operand forwarding plus ID/EX operand register: picks regfile / EX/MEM / MEM/WB
// data per source operand, inserts load-use bubbles and counts them.
module fwd_sel #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exmem_wen,
    input  logic [REG_AW-1:0] exmem_waddr,
    input  logic [DATA_W-1:0] exmem_wdata,
    input  logic              memwb_wen,
    input  logic [REG_AW-1:0] memwb_waddr,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic              hit_em,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] data
);
    logic nz, hit_mw;

    assign nz     = (addr != '0);
    assign hit_em = exmem_wen & (exmem_waddr == addr) & nz;
    assign hit_mw = memwb_wen & (memwb_waddr == addr) & nz;

    // EX/MEM holds the newest value, so it wins over MEM/WB
    always_comb begin
        sel  = 2'b00;
        data = rf_data;
        if (hit_em) begin
            sel  = 2'b01;
            data = exmem_wdata;
        end else if (hit_mw) begin
            sel  = 2'b10;
            data = memwb_wdata;
        end
    end
endmodule

module fwd_operand_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              exmem_wen,
    input  logic              exmem_is_load,
    input  logic [REG_AW-1:0] exmem_waddr,
    input  logic [DATA_W-1:0] exmem_wdata,
    input  logic              memwb_wen,
    input  logic [REG_AW-1:0] memwb_waddr,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic              load_use_stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam int NUM_OPS = 2;

    logic [NUM_OPS-1:0][REG_AW-1:0] op_addr;
    logic [NUM_OPS-1:0][DATA_W-1:0] op_rf, op_data;
    logic [NUM_OPS-1:0][1:0]        op_sel;
    logic [NUM_OPS-1:0]             op_hit_em;
    logic                           hz;

    assign op_addr = {rt_addr, rs_addr};
    assign op_rf   = {rt_data, rs_data};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_sel (
            .addr        (op_addr[i]),
            .rf_data     (op_rf[i]),
            .exmem_wen   (exmem_wen),
            .exmem_waddr (exmem_waddr),
            .exmem_wdata (exmem_wdata),
            .memwb_wen   (memwb_wen),
            .memwb_waddr (memwb_waddr),
            .memwb_wdata (memwb_wdata),
            .hit_em      (op_hit_em[i]),
            .sel         (op_sel[i]),
            .data        (op_data[i])
        );
    end

    // load result is not ready in EX/MEM; it becomes forwardable from MEM/WB next cycle
    assign hz             = in_valid & exmem_is_load & (|op_hit_em);
    assign load_use_stall = hz & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            opa        <= '0;
            opb        <= '0;
            sel_a      <= 2'b00;
            sel_b      <= 2'b00;
            bubble_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            sel_a     <= 2'b00;
            sel_b     <= 2'b00;
        end else if (!stall) begin
            if (hz) begin
                out_valid <= 1'b0;
                opa       <= '0;
                opb       <= '0;
                sel_a     <= 2'b00;
                sel_b     <= 2'b00;
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
            end else begin
                out_valid <= in_valid;
                opa       <= op_data[0];
                opb       <= op_data[1];
                sel_a     <= op_sel[0];
                sel_b     <= op_sel[1];
            end
        end
    end
endmodule

// File: doc/fwd_operand_reg.md
Name: fwd_operand_reg

Overview:
Parametrised forwarding stage for the pipelined CPU with forwarding. It replaces the separate 3-input operand muxes and the ID/EX operand register. For two source operands, it selects between register-file data, the EX/MEM result and the MEM/WB result. It detects load-use hazards and inserts a one-cycle bubble, registers the chosen operands into the EX stage under stall/flush control, and counts hazard bubbles.

Parameters:
DATA_W, 32, operand/result width in bits
REG_AW, 5, register address width; address 0 is hard-wired zero and never forwarded
CNT_W, 16, width of the load-use bubble counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ID stage holds a valid instruction
stall  input  1  downstream stall; hold all registered outputs
flush  input  1  squash: load a bubble into the EX register
rs_addr  input  REG_AW  source A register address
rt_addr  input  REG_AW  source B register address
rs_data  input  DATA_W  register-file read data A
rt_data  input  DATA_W  register-file read data B
exmem_wen  input  1  EX/MEM instruction writes a register
exmem_is_load  input  1  EX/MEM instruction is a load (result not yet available)
exmem_waddr  input  REG_AW  EX/MEM destination
exmem_wdata  input  DATA_W  EX/MEM ALU result
memwb_wen  input  1  MEM/WB instruction writes a register
memwb_waddr  input  REG_AW  MEM/WB destination
memwb_wdata  input  DATA_W  MEM/WB write-back data
load_use_stall  output  1  combinational; upstream (PC, IF/ID) must hold this cycle
out_valid  output  1  registered; EX operands valid
opa  output  DATA_W  registered operand A
opb  output  DATA_W  registered operand B
sel_a  output  2  registered select used for opa: 00 regfile, 01 EX/MEM, 10 MEM/WB
sel_b  output  2  registered select used for opb, same encoding
bubble_cnt  output  CNT_W  registered count of inserted load-use bubbles, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, opa=0, opb=0, sel_a=00, sel_b=00, bubble_cnt=0. Release takes effect on the next rising edge.
- Select per operand X (A uses rs, B uses rt), combinational:
  - hit_em = exmem_wen & exmem_waddr==X_addr & X_addr!=0
  - hit_mw = memwb_wen & memwb_waddr==X_addr & X_addr!=0
  - Priority: hit_em → 01; else hit_mw → 10; else 00.
  - Encoding 11 is never produced.
- Load-use hazard: hz = in_valid & exmem_is_load & (hit_em on A or hit_em on B). load_use_stall = hz & ~flush. The output does not depend on stall.
- Register update on each rising edge, priority highest first:
  1. flush: out_valid=0, opa=opb=0, sel=00.
  2. stall: hold every registered output, including bubble_cnt.
  3. hz: bubble; out_valid=0, opa=opb=0, sel=00, bubble_cnt+1 (saturating).
  4. otherwise: out_valid=in_valid; opa/opb/sel_a/sel_b take the muxed values. Data is captured even when in_valid=0.
- Latency: one cycle from ID inputs to EX outputs. After a bubble, the load sits in MEM/WB next cycle, so the held instruction forwards via sel=10 with no second bubble.
- flush together with hz: the flush wins; no bubble is counted and load_use_stall=0.
- stall together with hz: the outputs hold, but load_use_stall is still asserted so upstream also holds.
- bubble_cnt sticks at 2^CNT_W−1 and does not wrap.
- Both hits with the same address: EX/MEM (newest) wins.
- Reset asserted mid-stall or mid-hazard: all registered state clears immediately. load_use_stall follows its inputs only.

Test Plan:
1. Reset → all outputs 0. Release, then in_valid=1, rs=3, rt=4, no hits, rs_data=0x11, rt_data=0x22 → next edge: out_valid=1, opa=0x11, opb=0x22, sel=00/00.
2. exmem_wen=1, waddr=3, wdata=0xAA and memwb_wen=1, waddr=3, wdata=0xBB; rs=3 → opa=0xAA, sel_a=01. Repeat with exmem_waddr=9 → opa=0xBB, sel_a=10. rs=0 with both stages writing r0 → sel_a=00.
3. exmem_is_load=1, waddr=5, rt=5 → load_use_stall=1, next edge out_valid=0, bubble_cnt=1. Next cycle memwb_waddr=5, wdata=0xCC, exmem idle → opb=0xCC, sel_b=10, load_use_stall=0.
4. Valid capture, then stall=1 for 3 cycles with changing inputs → outputs frozen. flush and stall together → out_valid=0, opa=0.
5. Hazard condition with flush=1 → load_use_stall=0, bubble_cnt unchanged. With CNT_W=2, drive 5 hazards → bubble_cnt=3.
6. Drive rst_n low asynchronously between edges while out_valid=1 → outputs clear before the next edge.
